period_meter: RTL

Downstream consumer of the programmable clock divider's square-wave output. It measures each full period of a single-bit, clk-synchronous input in clk cycles, along with its high time. Each result goes to a control/monitor agent over a valid/ack handshake. Used to close the loop on divider settings: a divide value of N must read back as period N+1.

---
 rtl/period_meter.sv | 110 +++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures each period and high time of a clk-synchronous square wave
// and hands every completed window to a consumer over a valid/ack handshake.
module period_meter #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             ack,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARM, SKIP, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SETTLE_VAL = 4'(SETTLE);

  state_t           state;
  logic             sig_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [3:0]       skip_cnt;
  logic             rise;
  logic             counting;
  logic             done;
  logic             stalled;

  assign rise     = sig_in & ~sig_d;
  assign counting = (state == SKIP) || (state == MEASURE);
  assign done     = (state == MEASURE) && rise;
  assign stalled  = counting && !rise && (per_cnt == CNT_MAX);

  // A rise both closes the current window and opens the next, so the
  // reported values are the counters as they stood before the reload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sig_d     <= 1'b0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      skip_cnt  <= '0;
      valid     <= 1'b0;
      period    <= '0;
      high_time <= '0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sig_d <= sig_in;
      if (!enable) begin
        state   <= IDLE;
        valid   <= 1'b0;
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (rise && state != IDLE) begin
          per_cnt <= CNT_ONE;
          hi_cnt  <= CNT_ONE;
          timeout <= 1'b0;
        end else if (counting) begin
          if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
          if (sig_in && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_ONE;
        end

        if (done) begin
          if (!valid || ack) begin
            valid     <= 1'b1;
            period    <= per_cnt;
            high_time <= hi_cnt;
          end else begin
            overrun <= 1'b1;
          end
        end else if (valid && ack) begin
          valid <= 1'b0;
        end

        // A stalled window re-arms so the settle periods are discarded again.
        if (stalled) begin
          timeout <= 1'b1;
          state   <= ARM;
        end else begin
          case (state)
            IDLE: state <= ARM;
            ARM: begin
              if (rise) begin
                skip_cnt <= SETTLE_VAL;
                state    <= (SETTLE_VAL == 4'd0) ? MEASURE : SKIP;
              end
            end
            SKIP: begin
              if (rise) begin
                skip_cnt <= skip_cnt - 4'd1;
                if (skip_cnt <= 4'd1) state <= MEASURE;
              end
            end
            MEASURE: state <= MEASURE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
